// File: rtl/sram_ctrl.sv
// Synchronous initiator for a 256K x 16 async SRAM: one 32-bit word request becomes 0..2 halfword cycles.
// Optional `SRAM_CTRL_STATS_EN adds saturating read/write completion counters (rd_count, wr_count).
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [16:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
`ifdef SRAM_CTRL_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

  state_t            r_state, w_nxt_state;
  logic              r_half, w_nxt_half, r_pend, w_nxt_pend;
  logic [CW-1:0]     r_cnt, w_nxt_cnt;
  logic              r_we, w_we;
  logic [16:0]       r_addr, w_addr;
  logic [3:0]        r_be, w_be;
  logic [31:0]       r_wdata, w_wdata;
  logic [1:0][15:0]  r_buf;
  logic [31:0]       r_rdata;
  logic              r_rsp_valid;
  logic              r_ce_n, r_we_n, r_oe_n, r_ub_n, r_lb_n, r_dq_oe;
  logic [17:0]       r_sram_addr;
  logic [15:0]       r_dq_out;
  logic              w_ce_n, w_we_n, w_oe_n, w_ub_n, w_lb_n, w_dq_oe;
  logic [17:0]       w_sram_addr;
  logic [15:0]       w_dq_out;
  logic [1:0]        w_sel_be;
  logic              w_accept, w_cap;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_cap    = (r_state == STROBE) && (r_cnt == LAST) && !r_we;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_half  = r_half;
    w_nxt_pend  = r_pend;
    w_nxt_cnt   = r_cnt;
    w_we        = r_we;
    w_addr      = r_addr;
    w_be        = r_be;
    w_wdata     = r_wdata;
    case (r_state)
      IDLE: if (req_valid) begin
        w_we    = req_we;
        w_addr  = req_addr;
        w_be    = req_be;
        w_wdata = req_wdata;
        // Writes skip halves with no enabled bytes; reads always fetch both.
        if (!req_we || (|req_be[1:0])) begin
          w_nxt_half  = 1'b0;
          w_nxt_pend  = !req_we || (|req_be[3:2]);
          w_nxt_state = SETUP;
        end else if (|req_be[3:2]) begin
          w_nxt_half  = 1'b1;
          w_nxt_pend  = 1'b0;
          w_nxt_state = SETUP;
        end else begin
          w_nxt_state = DONE;
        end
      end
      SETUP: begin
        w_nxt_cnt   = '0;
        w_nxt_state = STROBE;
      end
      STROBE: begin
        if (r_cnt == LAST) w_nxt_state = RECOVER;
        else               w_nxt_cnt   = r_cnt + 1'b1;
      end
      RECOVER: begin
        if (r_pend) begin
          w_nxt_half  = 1'b1;
          w_nxt_pend  = 1'b0;
          w_nxt_state = SETUP;
        end else begin
          w_nxt_state = DONE;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase

    // Pin values are computed from the next state so the pins themselves are pure flops.
    w_sel_be    = w_we ? (w_nxt_half ? w_be[3:2] : w_be[1:0]) : 2'b11;
    w_ce_n      = !((w_nxt_state == SETUP) || (w_nxt_state == STROBE) || (w_nxt_state == RECOVER));
    w_oe_n      = !((w_nxt_state == STROBE) && !w_we);
    w_we_n      = !((w_nxt_state == STROBE) && w_we);
    w_lb_n      = w_ce_n | !w_sel_be[0];
    w_ub_n      = w_ce_n | !w_sel_be[1];
    w_dq_oe     = !w_ce_n && w_we;
    w_dq_out    = w_nxt_half ? w_wdata[31:16] : w_wdata[15:0];
    w_sram_addr = w_ce_n ? r_sram_addr : {w_addr, w_nxt_half};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_half      <= 1'b0;
      r_pend      <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_half      <= w_nxt_half;
      r_pend      <= w_nxt_pend;
      r_cnt       <= w_nxt_cnt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_be    <= req_be;
        r_wdata <= req_wdata;
      end
      if (w_cap) r_buf[r_half] <= SRAM_DQ;
      r_rsp_valid <= (w_nxt_state == DONE);
      if ((w_nxt_state == DONE) && !w_we) r_rdata <= r_buf;
      r_ce_n      <= w_ce_n;
      r_we_n      <= w_we_n;
      r_oe_n      <= w_oe_n;
      r_ub_n      <= w_ub_n;
      r_lb_n      <= w_lb_n;
      r_dq_oe     <= w_dq_oe;
      r_sram_addr <= w_sram_addr;
      r_dq_out    <= w_dq_out;
    end
  end

`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_nxt_state == DONE) begin
      if (!w_we && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_we && (r_wr_cnt != 16'hFFFF))  r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end
  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`endif

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'bz;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_UB_N = r_ub_n;
  assign SRAM_LB_N = r_lb_n;
  assign SRAM_CE_N = r_ce_n;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous initiator for the board's 256K x 16 asynchronous SRAM. It drives the chip's ADDR, DATA, WE_N, OE_N, UB_N, LB_N and CE_N pins.
- Converts single 32-bit word requests from the Y86 memory stage into one or two 16-bit SRAM cycles, with programmable strobe width.
- Sits between the processor's data/instruction memory port and the external SRAM pins.

Parameters:
- WAIT_CYCLES, 1, number of clock cycles OE_N/WE_N is held low per 16-bit access; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  17  32-bit word address.
- req_be  in  4  byte enables for writes; bit i enables req_wdata[8i+7:8i].
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse when a transaction completes (read or write).
- rsp_rdata  out  32  read data; holds its value until the next read completes.
- busy  out  1  high whenever state != IDLE.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  active-low SRAM controls.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N = 1.
  - SRAM_ADDR = 0; SRAM_DQ = Z.
  - rsp_valid = 0; rsp_rdata = 0; state = IDLE, so req_ready = 1 and busy = 0.
- Output timing: all SRAM pin outputs and the DQ output enable come from registers, so no glitches reach the pins.
- Request acceptance: a request is taken on the rising edge where req_valid && req_ready. req_we, req_addr, req_be and req_wdata are latched at that edge, so later changes on these inputs have no effect.
- Half mapping:
  - Low half: SRAM_ADDR = {req_addr,0}, carries bytes 1:0 (bits 15:0).
  - High half: SRAM_ADDR = {req_addr,1}, carries bytes 3:2 (bits 31:16).
- Reads: always access both halves with UB_N = LB_N = 0; req_be is ignored.
- Writes:
  - A half is skipped entirely if both of its be bits are 0.
  - Within an accessed half, LB_N = !be[even] and UB_N = !be[odd].
  - be = 0 makes no SRAM access and goes straight to DONE.
- FSM, per accessed half:
  - IDLE → SETUP: address, CE_N = 0 and (for writes) DQ are driven; WE_N = OE_N = 1 for 1 cycle.
  - SETUP → STROBE: OE_N = 0 (read) or WE_N = 0 (write) for WAIT_CYCLES cycles. A read captures SRAM_DQ into the matching half of an internal buffer on the last STROBE edge.
  - STROBE → RECOVER: strobes = 1; address, CE_N and DQ drive unchanged for 1 cycle (hold time).
  - After RECOVER: go to SETUP for the high half if it is pending, otherwise to DONE.
  - DONE: rsp_valid = 1 for one cycle. For reads, rsp_rdata is updated from the buffer in the same cycle. Then → IDLE.
- Latency, counted from the acceptance edge to the cycle with rsp_valid high:
  - Two halves: 2*(WAIT_CYCLES+2)+1 cycles.
  - One half: (WAIT_CYCLES+2)+1 cycles.
  - be = 0: 1 cycle.
- DQ ownership:
  - Driven only during SETUP, STROBE and RECOVER of a write; Z at all other times.
  - OE_N and WE_N are never both low.
  - DQ is never driven while OE_N = 0.
- Between transactions: CE_N returns high in IDLE and DONE. No new request can be accepted in the DONE cycle.
- Back-to-back requests: the earliest next acceptance is the first IDLE cycle after DONE.
- Reset asserted mid-transaction: all strobes and CE_N go high immediately (asynchronously), DQ is released, the transaction is dropped, and no rsp_valid is issued.

Optional Feature:
- Macro: SRAM_CTRL_STATS_EN.
- Defined:
  - Adds ports rd_count[15:0] out and wr_count[15:0] out.
  - Both reset to 0 and saturate at 16'hFFFF.
  - Each increments by 1 in the DONE cycle of a completed read or write respectively; be = 0 writes still count.
- Undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → all SRAM control pins = 1, SRAM_DQ = Z, req_ready = 1, rsp_valid = 0.
- Full write then read, WAIT_CYCLES = 1:
  - Write addr 17'h00005, be = 4'hF, wdata = 32'hDEADBEEF → SRAM model holds 16'hBEEF at 18'h0000A and 16'hDEAD at 18'h0000B.
  - rsp_valid arrives 7 cycles after acceptance.
  - Read of the same address → rsp_rdata = 32'hDEADBEEF, also after 7 cycles.
- Partial write:
  - Preload 18'h00010 = 16'h1111 and 18'h00011 = 16'h2222.
  - Write addr 17'h00008, be = 4'b0100, wdata = 32'h00AB0000 → only the high half is accessed, with LB_N = 0 and UB_N = 1.
  - Memory becomes 16'h1111 / 16'h22AB; rsp_valid arrives after 4 cycles.
- Timing with WAIT_CYCLES = 3:
  - OE_N is low for exactly 3 cycles per half.
  - Address is stable 1 cycle before and 1 cycle after each strobe.
  - OE_N and WE_N are never low together; DQ is Z whenever OE_N = 0.
- Reset mid-operation: assert rst_n = 0 during the first STROBE of a write → WE_N rises the same instant and memory at the high halfword is unchanged. After release, req_ready = 1 and no rsp_valid appears.
- Back-to-back (with SRAM_CTRL_STATS_EN defined): req_valid held high for 3 reads and 2 writes → each is accepted only in IDLE, with responses in order. Finish with rd_count = 3 and wr_count = 2.
